imm_extend_pipe: RTL and testbench
==================================

Name: imm_extend_pipe

Overview:
- Pipelined, parametrised immediate-extension unit for the pipelined ARM core; replaces the single-cycle extender in the decode path.
- Supports two additional immediate modes: data-processing rotated immediate with shifter carry-out, and plain 24-bit sign-extend.
- Two-stage pipeline with valid/ready handshake, back-pressure and flush.
- A tag travels with each result so it can be re-paired with its instruction.

Parameters:
- DATA_W, 32, result width; legal range 32..64; values above bit 31 are zero/sign fill.
- TAG_W, 4, width of the opaque tag passed through alongside each immediate.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- in_valid  in  1  request valid.
- in_ready  out  1  unit can accept a request this cycle.
- imm  in  24  instruction bits [23:0].
- imm_src  in  3  mode select (imm_src_e).
- carry_in  in  1  current C flag, used by rotated mode.
- tag_in  in  TAG_W  opaque tag.
- flush  in  1  discard all in-flight entries.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts the result.
- ext_imm  out  DATA_W  extended immediate.
- shift_carry  out  1  shifter carry-out.
- illegal  out  1  imm_src encoding was unsupported.
- tag_out  out  TAG_W  tag of the current result.

Behaviour:
- Reset (reset=0, asynchronous): both stage valids=0, out_valid=0, ext_imm=0, shift_carry=0, illegal=0, tag_out=0. in_ready=1 on the first edge after release.
- Modes (bits above the listed field are zero unless stated):
  - 000 ZX8: {0, imm[7:0]}.
  - 001 ZX12: {0, imm[11:0]}.
  - 010 BR: sign-extend {imm[23:0], 2'b00} to DATA_W.
  - 011 ROT: 32-bit value {24'b0, imm[7:0]} rotated right by 2*imm[11:8], then zero-extended to DATA_W. shift_carry = carry_in if imm[11:8]==0, else rotated bit 31.
  - 100 SX24: sign-extend imm[23:0] to DATA_W.
  - 101..111: ext_imm=0, illegal=1.
  - shift_carry = carry_in in every mode other than ROT.
- Stage 1 (S1): registers imm, imm_src, carry_in, tag on the transfer edge (in_valid & in_ready).
- Stage 2 (S2): registers the core result (ext_imm, shift_carry, illegal, tag). Outputs are driven directly from S2 flops.
- Latency: 2 clk edges from the input transfer to out_valid=1 when unstalled. Throughput: 1 per cycle.
- Handshake:
  - out_valid = S2 valid. An S2 entry retires when out_valid & out_ready.
  - S2 loads when it is empty or retiring.
  - S1 advances into S2 under that same condition.
  - in_ready = !S1_valid | S1_advances. This is a combinational path from out_ready.
- Stall: S2 data holds stable while out_valid & !out_ready; values must not change.
- Full: with both stages full and out_ready=0, in_ready=0 and at most 2 entries are held. No entry is lost, duplicated or reordered.
- Flush:
  - While flush=1, in_ready=0.
  - On the next edge both valids clear; any output transfer in that cycle still completes.
  - flush has priority over all other events.
- Illegal entries flow through the pipeline normally; only the illegal flag marks them.
- Reset asserted mid-operation empties the pipeline immediately (asynchronously). In-flight entries are lost by design.
- Data registers may be non-reset; valids and outputs must reset.

Decomposition:
- Package imm_extend_pkg holds:
  - typedef enum logic [2:0] imm_src_e (ZX8, ZX12, BR, ROT, SX24).
  - Constant IMM_W=24.
  - Constant ROT_BASE_W=32.
- Sub-module imm_extend_core: purely combinational mode decode, rotate and carry logic, parametrised by DATA_W. It sits between S1 and S2 so it can be unit-tested standalone.

Test Plan:
- ZX8, imm=0x123456, tag=3, out_ready=1 -> 2 edges later out_valid=1, ext_imm=0x00000056, tag_out=3, illegal=0.
- BR, imm=0xFFFFFE -> ext_imm=0xFFFFFFF8; with DATA_W=64 -> 0xFFFFFFFFFFFFFFF8.
- ROT, imm=0x0004FF, carry_in=0 -> ext_imm=0xFF000000, shift_carry=1. ROT, imm=0x0000AB, carry_in=1 -> ext_imm=0x000000AB, shift_carry=1.
- Back-to-back ZX12 imm=0x001,0x002,0x003 with out_ready=0 for 4 cycles -> in_ready drops after 2 accepts; on release, 0x1,0x2,0x3 emerge in order on consecutive cycles with no loss.
- Pipeline full, pulse flush with out_ready=0 -> next cycle out_valid=0, in_ready=1; a following SX24 imm=0x800000 -> ext_imm=0xFF800000.
- imm_src=111 -> ext_imm=0, illegal=1. Assert reset mid-stream -> out_valid=0 immediately and all outputs=0.

Source files
------------

// File: rtl/imm_extend_pkg.sv
// Shared types and constants for the pipelined immediate-extension unit.
// The rotate helper keeps the data-processing immediate arithmetic in one place.
package imm_extend_pkg;

    localparam int IMM_W       = 24;
    localparam int ROT_BASE_W  = 32;
    localparam int ROT_AMT_W   = $clog2(ROT_BASE_W);

    typedef enum logic [2:0] {
        ZX8  = 3'b000,
        ZX12 = 3'b001,
        BR   = 3'b010,
        ROT  = 3'b011,
        SX24 = 3'b100
    } imm_src_e;

    // Stage-1 payload; imm_src stays raw so unsupported encodings survive to decode.
    typedef struct packed {
        logic [IMM_W-1:0] imm;
        logic [2:0]       imm_src;
        logic             carry;
    } s1_req_t;

    function automatic logic [ROT_BASE_W-1:0] rotr32(
        input logic [ROT_BASE_W-1:0] value,
        input logic [ROT_AMT_W-1:0]  amount
    );
        logic [2*ROT_BASE_W-1:0] w_double;
        w_double = {value, value} >> amount;
        return w_double[ROT_BASE_W-1:0];
    endfunction

endpackage

// File: rtl/imm_extend_core.sv
// Combinational immediate decode: mode select, rotate and shifter carry-out.
// Sits between the two pipeline stages and can be exercised standalone.
module imm_extend_core
    import imm_extend_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic [IMM_W-1:0]  i_imm,
    input  logic [2:0]        i_imm_src,
    input  logic              i_carry_in,
    output logic [DATA_W-1:0] o_ext_imm,
    output logic              o_shift_carry,
    output logic              o_illegal
);

    logic [ROT_BASE_W-1:0] w_rot_base;
    logic [ROT_BASE_W-1:0] w_rot;
    logic                  w_rot_zero;

    assign w_rot_base = {{(ROT_BASE_W-8){1'b0}}, i_imm[7:0]};
    assign w_rot      = rotr32(w_rot_base, {i_imm[11:8], 1'b0});
    assign w_rot_zero = (i_imm[11:8] == 4'd0);

    always_comb begin
        // NOTE: every output gets a default before the case so no path leaves one unassigned (no latch).
        o_ext_imm     = '0;
        o_shift_carry = i_carry_in;
        o_illegal     = 1'b0;
        case (i_imm_src)
            ZX8:  o_ext_imm = DATA_W'(i_imm[7:0]);
            ZX12: o_ext_imm = DATA_W'(i_imm[11:0]);
            BR:   o_ext_imm = DATA_W'($signed({i_imm, 2'b00}));
            ROT: begin
                o_ext_imm     = DATA_W'(w_rot);
                o_shift_carry = w_rot_zero ? i_carry_in : w_rot[ROT_BASE_W-1];
            end
            SX24: o_ext_imm = DATA_W'($signed(i_imm));
            default: o_illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/imm_extend_pipe.sv
// Two-stage immediate extender with valid/ready handshake, back-pressure and flush.
// S1 captures the request, S2 holds the decoded result that drives the outputs.
module imm_extend_pipe
    import imm_extend_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int TAG_W  = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [IMM_W-1:0]  imm,
    input  logic [2:0]        imm_src,
    input  logic              carry_in,
    input  logic [TAG_W-1:0]  tag_in,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] ext_imm,
    output logic              shift_carry,
    output logic              illegal,
    output logic [TAG_W-1:0]  tag_out
);

    logic              r_s1_valid;
    s1_req_t           r_s1_req;
    logic [TAG_W-1:0]  r_s1_tag;

    logic              r_s2_valid;
    logic [DATA_W-1:0] r_ext_imm;
    logic              r_shift_carry;
    logic              r_illegal;
    logic [TAG_W-1:0]  r_tag;

    logic              w_s2_load;
    logic              w_s1_accept;
    logic              w_s2_capture;
    logic [DATA_W-1:0] w_core_ext;
    logic              w_core_carry;
    logic              w_core_illegal;

    // S2 takes a new entry when empty or when its current one retires this edge.
    assign w_s2_load    = !r_s2_valid || out_ready;
    assign in_ready     = !flush && (!r_s1_valid || w_s2_load);
    assign w_s1_accept  = in_valid && in_ready;
    assign w_s2_capture = !flush && w_s2_load && r_s1_valid;

    always_ff @(posedge clk or negedge reset) begin
        // NOTE: state uses non-blocking assignments so every flop samples pre-edge values.
        if (!reset) begin
            r_s1_valid <= 1'b0;
            r_s2_valid <= 1'b0;
        end else if (flush) begin
            r_s1_valid <= 1'b0;
            r_s2_valid <= 1'b0;
        end else begin
            if (w_s2_load) begin
                r_s2_valid <= r_s1_valid;
            end
            if (w_s1_accept) begin
                r_s1_valid <= 1'b1;
            end else if (w_s2_load) begin
                r_s1_valid <= 1'b0;
            end
        end
    end

    // NOTE: S1 payload is qualified by r_s1_valid, so it needs no reset.
    always_ff @(posedge clk) begin
        if (w_s1_accept) begin
            r_s1_req.imm     <= imm;
            r_s1_req.imm_src <= imm_src;
            r_s1_req.carry   <= carry_in;
            r_s1_tag         <= tag_in;
        end
    end

    imm_extend_core #(
        .DATA_W (DATA_W)
    ) u_core (
        .i_imm         (r_s1_req.imm),
        .i_imm_src     (r_s1_req.imm_src),
        .i_carry_in    (r_s1_req.carry),
        .o_ext_imm     (w_core_ext),
        .o_shift_carry (w_core_carry),
        .o_illegal     (w_core_illegal)
    );

    // Output flops are reset so a cleared pipeline presents all-zero results.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_ext_imm     <= '0;
            r_shift_carry <= 1'b0;
            r_illegal     <= 1'b0;
            r_tag         <= '0;
        end else if (w_s2_capture) begin
            r_ext_imm     <= w_core_ext;
            r_shift_carry <= w_core_carry;
            r_illegal     <= w_core_illegal;
            r_tag         <= r_s1_tag;
        end
    end

    assign out_valid   = r_s2_valid;
    assign ext_imm     = r_ext_imm;
    assign shift_carry = r_shift_carry;
    assign illegal     = r_illegal;
    assign tag_out     = r_tag;

endmodule

// File: tb/tb_imm_extend_pipe.sv
// Directed bench for imm_extend_pipe: 32-bit and 64-bit instances share stimulus.
// Expected values are hand-computed constants.
module tb_imm_extend_pipe;
    import imm_extend_pkg::*;

    localparam int TAG_W = 4;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              in_valid;
    logic [IMM_W-1:0]  imm;
    logic [2:0]        imm_src;
    logic              carry_in;
    logic [TAG_W-1:0]  tag_in;
    logic              flush;
    logic              out_ready;

    logic              in_ready, out_valid, shift_carry, illegal;
    logic [31:0]       ext_imm;
    logic [TAG_W-1:0]  tag_out;

    logic              in_ready64, out_valid64, shift_carry64, illegal64;
    logic [63:0]       ext_imm64;
    logic [TAG_W-1:0]  tag_out64;

    int n_checks = 0;
    int n_fail   = 0;

    imm_extend_pipe #(.DATA_W(32), .TAG_W(TAG_W)) dut (
        .clk         (clk),
        .reset       (rst_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .imm         (imm),
        .imm_src     (imm_src),
        .carry_in    (carry_in),
        .tag_in      (tag_in),
        .flush       (flush),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .ext_imm     (ext_imm),
        .shift_carry (shift_carry),
        .illegal     (illegal),
        .tag_out     (tag_out)
    );

    imm_extend_pipe #(.DATA_W(64), .TAG_W(TAG_W)) dut64 (
        .clk         (clk),
        .reset       (rst_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready64),
        .imm         (imm),
        .imm_src     (imm_src),
        .carry_in    (carry_in),
        .tag_in      (tag_in),
        .flush       (flush),
        .out_valid   (out_valid64),
        .out_ready   (out_ready),
        .ext_imm     (ext_imm64),
        .shift_carry (shift_carry64),
        .illegal     (illegal64),
        .tag_out     (tag_out64)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [2:0] src, input logic [23:0] value, input logic c, input logic [3:0] t);
        in_valid = 1'b1;
        imm_src  = src;
        imm      = value;
        carry_in = c;
        tag_in   = t;
    endtask

    // Sends one request and advances to the cycle its result should be visible.
    task automatic single(input string tag, input logic [2:0] src, input logic [23:0] value,
                          input logic c, input logic [3:0] t);
        drive(src, value, c, t);
        step();
        in_valid = 1'b0;
        check({tag, ".lat1"}, out_valid, 1'b0);
        step();
    endtask

    task automatic check_out(input string tag, input logic [31:0] e, input logic sc,
                             input logic il, input logic [3:0] t);
        check({tag, ".valid"}, out_valid, 1'b1);
        check({tag, ".ext"}, ext_imm, e);
        check({tag, ".carry"}, shift_carry, sc);
        check({tag, ".illegal"}, illegal, il);
        check({tag, ".tag"}, tag_out, t);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; imm = '0; imm_src = '0; carry_in = 1'b0;
        tag_in = '0; flush = 1'b0; out_ready = 1'b1;

        #12;
        check("rst.valid", out_valid, 1'b0);
        check("rst.ext", ext_imm, 32'h0);
        check("rst.carry", shift_carry, 1'b0);
        check("rst.illegal", illegal, 1'b0);
        check("rst.tag", tag_out, 4'h0);
        #1 rst_n = 1'b1;
        step();
        check("rst.in_ready", in_ready, 1'b1);

        // Mode coverage with the consumer always ready.
        single("zx8", 3'b000, 24'h123456, 1'b0, 4'd3);
        check_out("zx8", 32'h0000_0056, 1'b0, 1'b0, 4'd3);
        single("br", 3'b010, 24'hFFFFFE, 1'b1, 4'd4);
        check_out("br", 32'hFFFF_FFF8, 1'b1, 1'b0, 4'd4);
        check("br.ext64", ext_imm64, 64'hFFFF_FFFF_FFFF_FFF8);
        single("rot8", 3'b011, 24'h0004FF, 1'b0, 4'd5);
        check_out("rot8", 32'hFF00_0000, 1'b1, 1'b0, 4'd5);
        check("rot8.ext64", ext_imm64, 64'h0000_0000_FF00_0000);
        single("rot0", 3'b011, 24'h0000AB, 1'b1, 4'd6);
        check_out("rot0", 32'h0000_00AB, 1'b1, 1'b0, 4'd6);
        single("rot30", 3'b011, 24'h000F01, 1'b1, 4'd7);
        check_out("rot30", 32'h0000_0004, 1'b0, 1'b0, 4'd7);
        single("zx12", 3'b001, 24'hABCDEF, 1'b1, 4'd8);
        check_out("zx12", 32'h0000_0DEF, 1'b1, 1'b0, 4'd8);
        single("sx24p", 3'b100, 24'h7FFFFF, 1'b0, 4'd9);
        check_out("sx24p", 32'h007F_FFFF, 1'b0, 1'b0, 4'd9);
        single("ill7", 3'b111, 24'hFFFFFF, 1'b0, 4'd10);
        check_out("ill7", 32'h0, 1'b0, 1'b1, 4'd10);
        single("ill5", 3'b101, 24'h00F0F0, 1'b1, 4'd11);
        check_out("ill5", 32'h0, 1'b1, 1'b1, 4'd11);
        step();
        check("idle.valid", out_valid, 1'b0);

        // Back-pressure: three ZX12 requests against a stalled consumer.
        out_ready = 1'b0;
        drive(3'b001, 24'h000001, 1'b0, 4'd1);
        #1 check("bp.rdy0", in_ready, 1'b1);
        step();
        drive(3'b001, 24'h000002, 1'b0, 4'd2);
        check("bp.rdy1", in_ready, 1'b1);
        step();
        drive(3'b001, 24'h000003, 1'b0, 4'd3);
        check("bp.full_rdy", in_ready, 1'b0);
        check_out("bp.hold0", 32'h1, 1'b0, 1'b0, 4'd1);
        step();
        check_out("bp.hold1", 32'h1, 1'b0, 1'b0, 4'd1);
        check("bp.full_rdy2", in_ready, 1'b0);
        step();
        check_out("bp.hold2", 32'h1, 1'b0, 1'b0, 4'd1);
        out_ready = 1'b1;
        #1 check("bp.release_rdy", in_ready, 1'b1);
        step();
        in_valid = 1'b0;
        check_out("bp.out2", 32'h2, 1'b0, 1'b0, 4'd2);
        step();
        check_out("bp.out3", 32'h3, 1'b0, 1'b0, 4'd3);
        step();
        check("bp.drain", out_valid, 1'b0);

        // Flush a full pipeline while an offered request must be refused.
        out_ready = 1'b0;
        drive(3'b000, 24'h000011, 1'b0, 4'd1);
        step();
        drive(3'b000, 24'h000022, 1'b0, 4'd2);
        step();
        drive(3'b000, 24'h000033, 1'b0, 4'd3);
        check("fl.full_rdy", in_ready, 1'b0);
        flush = 1'b1;
        #1 check("fl.rdy_during", in_ready, 1'b0);
        step();
        flush = 1'b0;
        in_valid = 1'b0;
        #1 check("fl.valid", out_valid, 1'b0);
        check("fl.rdy_after", in_ready, 1'b1);
        out_ready = 1'b1;
        single("sx24n", 3'b100, 24'h800000, 1'b0, 4'd12);
        check_out("sx24n", 32'hFF80_0000, 1'b0, 1'b0, 4'd12);
        check("sx24n.ext64", ext_imm64, 64'hFFFF_FFFF_FF80_0000);
        step();
        check("fl.drain", out_valid, 1'b0);

        // Asynchronous reset with two entries in flight.
        out_ready = 1'b0;
        single("mid", 3'b011, 24'h0004FF, 1'b0, 4'd7);
        check_out("mid.pre", 32'hFF00_0000, 1'b1, 1'b0, 4'd7);
        drive(3'b000, 24'h000099, 1'b1, 4'd5);
        step();
        in_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        check("arst.valid", out_valid, 1'b0);
        check("arst.ext", ext_imm, 32'h0);
        check("arst.carry", shift_carry, 1'b0);
        check("arst.illegal", illegal, 1'b0);
        check("arst.tag", tag_out, 4'h0);
        check("arst.valid64", out_valid64, 1'b0);
        check("arst.ext64", ext_imm64, 64'h0);
        check("arst.misc64", {shift_carry64, illegal64, tag_out64}, 6'h0);
        #2 rst_n = 1'b1;
        out_ready = 1'b1;
        step();
        check("arst.rdy", in_ready, 1'b1);
        check("arst.rdy64", in_ready64, 1'b1);
        step();
        check("arst.empty", out_valid, 1'b0);
        step();
        check("arst.empty2", out_valid, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
